// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Four-digit multiplexed seven-segment driver for a common-anode display.
//   It latches five BCD digits and a sign flag. From those it derives
//   leading-zero blanking, the placement of a minus sign, and overflow.
//   It then scans one digit position per refresh slot.
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   load    single-cycle strobe capturing bcd_* and neg
//   bcd_u .. bcd_tt   units .. ten-thousands digits
//   neg     value is negative
//   an      anode enables, active-low, an[0] = rightmost position
//   seg     segments {g,f,e,d,c,b,a}, active-low
//   dp      decimal point, active-low, always off
//   ovf     latched value does not fit in four positions
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] bcd_u,
  input  logic [3:0] bcd_t,
  input  logic [3:0] bcd_h,
  input  logic [3:0] bcd_th,
  input  logic [3:0] bcd_tt,
  input  logic       neg,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       ovf
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [3:0]    u_r, t_r, h_r, th_r, tt_r;
  logic          neg_r;

  logic          tick_s;
  logic [1:0]    next_idx_s;
  logic [3:0]    digit_s;
  logic          blank_s;
  logic          sign_s;
  logic [6:0]    seg_next_s;

  // Active-low segment code for one digit; codes 10..15 show blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Overflow: a fifth digit, or a minus sign that would need a fifth position.
  function automatic logic calc_ovf(input logic [3:0] tt, input logic [3:0] th,
                                    input logic [3:0] h,  input logic [3:0] t,
                                    input logic [3:0] u,  input logic       ng);
    logic nz;
    nz = (tt != 4'd0) || (th != 4'd0) || (h != 4'd0) || (t != 4'd0) || (u != 4'd0);
    return (tt != 4'd0) || (ng && nz && (th != 4'd0));
  endfunction

  assign tick_s     = (cnt_r == CNT_MAX);
  assign next_idx_s = idx_r + 2'd1;

  // Pattern for the position the next tick selects, from the current latched values.
  // The sign sits at Pk when P(k-1) is the highest nonzero position.
  // This implies that Pk itself would otherwise be blank.
  always_comb begin
    digit_s = u_r;
    blank_s = 1'b0;
    sign_s  = 1'b0;
    case (next_idx_s)
      2'd0: begin
        digit_s = u_r;
        blank_s = 1'b0;
        sign_s  = 1'b0;
      end
      2'd1: begin
        digit_s = t_r;
        blank_s = (th_r == 4'd0) && (h_r == 4'd0) && (t_r == 4'd0);
        sign_s  = neg_r && blank_s && (u_r != 4'd0);
      end
      2'd2: begin
        digit_s = h_r;
        blank_s = (th_r == 4'd0) && (h_r == 4'd0);
        sign_s  = neg_r && blank_s && (t_r != 4'd0);
      end
      2'd3: begin
        digit_s = th_r;
        blank_s = (th_r == 4'd0);
        sign_s  = neg_r && blank_s && (h_r != 4'd0);
      end
      default: begin
        digit_s = u_r;
        blank_s = 1'b1;
        sign_s  = 1'b0;
      end
    endcase
    seg_next_s = ovf ? SEG_DASH :
                 sign_s ? SEG_DASH :
                 blank_s ? SEG_BLANK : seg_code(digit_s);
  end

  // Refresh counter, digit index and the registered anode/segment outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= 2'd3;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (tick_s) begin
        cnt_r <= '0;
        idx_r <= next_idx_s;
        an    <= ~(4'b0001 << next_idx_s);
        seg   <= seg_next_s;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Digit/sign latch; ovf is derived from the incoming values on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_r   <= 4'd0;
      t_r   <= 4'd0;
      h_r   <= 4'd0;
      th_r  <= 4'd0;
      tt_r  <= 4'd0;
      neg_r <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      u_r   <= bcd_u;
      t_r   <= bcd_t;
      h_r   <= bcd_h;
      th_r  <= bcd_th;
      tt_r  <= bcd_tt;
      neg_r <= neg;
      ovf   <= calc_ovf(bcd_tt, bcd_th, bcd_h, bcd_t, bcd_u, neg);
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed four-digit seven-segment driver that sits directly downstream of the binary-to-BCD converter. It latches the five BCD digits (units through ten-thousands) plus a sign flag and applies leading-zero blanking, negative-sign placement and overflow detection. It then time-multiplexes the result onto a common-anode four-digit display with active-low anodes and segments.

## Interface

- REFRESH_DIV, default 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit); legal range ≥ 2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle strobe that captures all digit inputs and neg
- bcd_u  in  4  units digit
- bcd_t  in  4  tens digit
- bcd_h  in  4  hundreds digit
- bcd_th  in  4  thousands digit
- bcd_tt  in  4  ten-thousands digit
- neg  in  1  value is negative
- an  out  4  anode enables, active-low; an[0] is the rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; held at 1
- ovf  out  1  latched value cannot be shown in 4 positions

## Operation

- Latch: on a clk edge with load=1, register all five digits and neg. ovf is recomputed from the new values in the same edge.
- Refresh counter: cnt counts 0..REFRESH_DIV-1 and wraps. A tick occurs on the edge where cnt = REFRESH_DIV-1.
- Digit index: idx is 2 bits and advances 3→0→1→2→3 on every tick.
- Output registers: on each tick, an and seg load the pattern for the new idx. an has only bit idx low. seg is computed from the latched values as they stand before that edge.
- Positions P3..P0 initially hold th,h,t,u.
- Blanking: Pk (k=3..1) is blank when its digit and every higher digit among th..t are 0. P0 is never blanked.
- Sign: applies only when neg=1 and the latched value is nonzero. Let m be the highest nonzero position. A '-' is placed at P(m+1).
- Overflow: ovf = (tt≠0) OR (neg=1, value≠0, th≠0). When ovf=1, all four positions show '-'.
- Digit codes:
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h
  - 5=12h, 6=02h, 7=78h, 8=00h, 9=10h
  - '-'=3Fh, blank=7Fh
  - Any digit value 10..15 displays as blank. It does not assert ovf.

## Timing

- Reset values, applied asynchronously:
  - cnt=0, idx=3
  - an=4'b1111, seg=7'h7F, dp=1, ovf=0
  - all latched digits=0, latched neg=0
- First display after reset: the first tick comes REFRESH_DIV cycles after rst deasserts. It drives idx=0, an=1110, seg=40h ("0").
- Full scan period: 4·REFRESH_DIV cycles. Each anode is low for exactly REFRESH_DIV cycles and exactly one anode is low at any time after the first tick.
- load latency:
  - ovf is valid 1 cycle after the load edge.
  - Display content changes at the first tick strictly after the load edge.
- Simultaneous load and tick in the same cycle: the tick uses the old latched values. The new values appear from the following tick.
- Back-to-back loads: the last one wins. No handshake exists and load is never stalled.
- Reset mid-scan: outputs return immediately to all-off. The scan restarts from idx=3 with cnt=0.
- an/seg change only on tick edges, so they are glitch-free between ticks.

## Test plan

Test plan uses REFRESH_DIV=4.

- Reset then idle, no load:
  - an stays 1111 for 4 cycles after rst drops.
  - Scan then cycles 1110, 1101, 1011, 0111 with seg = 40h, 7Fh, 7Fh, 7Fh.
  - ovf=0.
- load th,h,t,u = 1,2,3,4 with neg=0, tt=0:
  - Positions P3..P0 show seg 79h, 24h, 30h, 19h.
  - Each anode is held low for exactly 4 cycles.
- load 0,0,4,2 with neg=1:
  - P0=24h, P1=19h, P2=3Fh, P3=7Fh.
  - ovf=0.
- Overflow, neg case: load th=1 (value 1000) with neg=1.
  - ovf=1 one cycle after load.
  - All positions show 3Fh.
- Overflow, tt case: load tt=1, th..u = 6,3,8,3.
  - ovf=1.
  - All positions show 3Fh.
- Edge cases:
  - neg=1 with an all-zero value gives P0=40h, P1..P3 blank, ovf=0.
  - Asserting load exactly on a tick edge shows old data at that tick and new data at the next.
  - Asserting rst mid-slot forces an=1111 and seg=7Fh in the same cycle.
